// File: rtl/axi_wb_write_arbiter.sv
// axi_wb_write_arbiter
// Shares one AXI write channel between two requesters:
//   - the write buffer, which drains a 256-bit dirty line as an 8-beat x 32-bit INCR burst;
//   - the uncached store path, which sends a single 32-bit beat.
// The arbiter grants one requester, latches its request, and then runs AW, W and B strictly
// in that order. When the B response arrives it returns a one-cycle done pulse to the winner.
// Every output is registered.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   unc_req/addr/data/wstrb       uncached store request (held until unc_done)
//   unc_done                      one-cycle pulse on the uncached B response
//   wb_req/addr/data              line drain request (held until wb_done); addr[4:0] ignored
//   wb_done                       one-cycle pulse on the line B response
//   aw*/w*/b*                     AXI write address, data and response channels
//   busy_o                        high whenever a transaction is in flight
//   err_o                         one-cycle pulse alongside done when bresp is not OKAY
module axi_wb_write_arbiter #(
    parameter int              ID_W  = 4,
    parameter logic [ID_W-1:0] AW_ID = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            unc_req,
    input  logic [31:0]     unc_addr,
    input  logic [31:0]     unc_data,
    input  logic [3:0]      unc_wstrb,
    output logic            unc_done,
    input  logic            wb_req,
    input  logic [31:0]     wb_addr,
    input  logic [255:0]    wb_data,
    output logic            wb_done,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic            busy_o,
    output logic            err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [7:0][31:0] line_r, line_s;      // latched beats; an uncached store uses beat 0 only
    logic [3:0]      strb_r, strb_s;
    logic            grant_unc_r, grant_unc_s;
    logic            last_unc_r, last_unc_s;
    logic            pick_unc_s;
    logic [2:0]      beat_cnt_r, beat_cnt_s, beat_nxt_s;

    logic [31:0]     awaddr_s;
    logic [7:0]      awlen_s;
    logic [2:0]      awsize_s;
    logic [1:0]      awburst_s;
    logic            awvalid_s;
    logic [31:0]     wdata_s;
    logic [3:0]      wstrb_s;
    logic            wlast_s, wvalid_s, bready_s;
    logic            unc_done_s, wb_done_s, err_s;

    // bid is not checked and the low line-address bits are forced to zero
    logic            unused_ok_s;
    assign unused_ok_s = ^{bid, wb_addr[4:0]};

    assign beat_nxt_s = beat_cnt_r + 3'd1;

    // Next-state and next-output logic for the AW -> W -> B sequence
    always_comb begin
        state_s     = state_r;
        line_s      = line_r;
        strb_s      = strb_r;
        grant_unc_s = grant_unc_r;
        last_unc_s  = last_unc_r;
        pick_unc_s  = 1'b0;
        beat_cnt_s  = beat_cnt_r;
        awaddr_s    = awaddr;
        awlen_s     = awlen;
        awsize_s    = awsize;
        awburst_s   = awburst;
        awvalid_s   = awvalid;
        wdata_s     = wdata;
        wstrb_s     = wstrb;
        wlast_s     = wlast;
        wvalid_s    = wvalid;
        bready_s    = bready;
        unc_done_s  = 1'b0;
        wb_done_s   = 1'b0;
        err_s       = 1'b0;

        case (state_r)
            IDLE: begin
                // During a done pulse the winner's request is still high. It is stale,
                // so both requests are ignored for that cycle.
                if ((unc_req || wb_req) && !(unc_done || wb_done)) begin
                    // Under contention, alternate away from the last uncached winner
                    pick_unc_s  = unc_req && (!wb_req || !last_unc_r);
                    grant_unc_s = pick_unc_s;
                    last_unc_s  = pick_unc_s;
                    if (pick_unc_s) begin
                        line_s   = {224'd0, unc_data};
                        strb_s   = unc_wstrb;
                        awaddr_s = unc_addr;
                        awlen_s  = 8'd0;
                    end else begin
                        line_s   = wb_data;
                        strb_s   = 4'hF;
                        awaddr_s = {wb_addr[31:5], 5'b00000};
                        awlen_s  = 8'd7;
                    end
                    awsize_s  = 3'd2;
                    awburst_s = 2'b01;
                    awvalid_s = 1'b1;
                    state_s   = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (awready) begin
                    awvalid_s  = 1'b0;
                    wvalid_s   = 1'b1;
                    wdata_s    = line_r[0];
                    wstrb_s    = strb_r;
                    wlast_s    = (awlen[2:0] == 3'd0);
                    beat_cnt_s = 3'd0;
                    state_s    = DATA;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (wready) begin
                    if (wlast) begin
                        wvalid_s   = 1'b0;
                        wlast_s    = 1'b0;
                        beat_cnt_s = 3'd0;
                        bready_s   = 1'b1;
                        state_s    = RESP;
                    end else begin
                        beat_cnt_s = beat_nxt_s;
                        wdata_s    = line_r[beat_nxt_s];
                        wlast_s    = (beat_nxt_s == awlen[2:0]);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            RESP: begin
                if (bvalid) begin
                    bready_s   = 1'b0;
                    unc_done_s = grant_unc_r;
                    wb_done_s  = !grant_unc_r;
                    err_s      = (bresp != 2'b00);
                    state_s    = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched request, beat counter and registered AXI/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_r      <= '0;
            strb_r      <= 4'd0;
            grant_unc_r <= 1'b0;
            last_unc_r  <= 1'b0;
            beat_cnt_r  <= 3'd0;
            awid        <= AW_ID;
            awaddr      <= 32'd0;
            awlen       <= 8'd0;
            awsize      <= 3'd0;
            awburst     <= 2'd0;
            awvalid     <= 1'b0;
            wdata       <= 32'd0;
            wstrb       <= 4'd0;
            wlast       <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            unc_done    <= 1'b0;
            wb_done     <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            line_r      <= line_s;
            strb_r      <= strb_s;
            grant_unc_r <= grant_unc_s;
            last_unc_r  <= last_unc_s;
            beat_cnt_r  <= beat_cnt_s;
            awid        <= AW_ID;
            awaddr      <= awaddr_s;
            awlen       <= awlen_s;
            awsize      <= awsize_s;
            awburst     <= awburst_s;
            awvalid     <= awvalid_s;
            wdata       <= wdata_s;
            wstrb       <= wstrb_s;
            wlast       <= wlast_s;
            wvalid      <= wvalid_s;
            bready      <= bready_s;
            unc_done    <= unc_done_s;
            wb_done     <= wb_done_s;
            err_o       <= err_s;
            busy_o      <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_axi_wb_write_arbiter.sv
// Self-checking bench for axi_wb_write_arbiter. Each cycle it observes the DUT outputs
// about 1 time unit after the rising edge. It then drives the requester and slave inputs for
// that cycle and checks everything against a transaction-level model. The model predicts
// three things from the request rules:
//   - when a grant is due and who should win it;
//   - the expected AW fields, beats and strobes;
//   - the done and error pulses.
module tb_axi_wb_write_arbiter;
    localparam int ID_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            unc_req, wb_req;
    logic [31:0]     unc_addr, unc_data, wb_addr;
    logic [3:0]      unc_wstrb;
    logic [255:0]    wb_data;
    logic            unc_done, wb_done;
    logic [ID_W-1:0] awid, bid;
    logic [31:0]     awaddr, wdata;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst, bresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]      wstrb;
    logic            busy_o, err_o;

    axi_wb_write_arbiter #(.ID_W(ID_W), .AW_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .unc_req(unc_req), .unc_addr(unc_addr), .unc_data(unc_data), .unc_wstrb(unc_wstrb),
        .unc_done(unc_done),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_done(wb_done),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_unc;
        logic [31:0]  addr;
        logic [7:0]   len;
        logic [255:0] data;
        logic [3:0]   strb;
        logic [1:0]   bresp;
    } txn_t;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // stimulus controls
    int unc_left, wb_left, req_pct, bp_mode, err_mode;
    bit keep_inputs;
    int aw_cnt;
    bit wtog;

    // reference model state
    txn_t cur = '0;
    txn_t pred_txn = '0;
    bit   grant_pred, model_busy, have_cur, resp_m, resp_pend, aw_done_m, last_unc_m;
    int   beats_seen;
    bit   awv_prev, aw_stall_prev, w_stall_prev, unc_done_prev, wb_done_prev;
    logic [63:0] aw_snap, w_snap;
    int   rise_unc, rise_wb, lat_unc, lat_wb, n_err, n_aw_stall, n_w_stall;
    bit   grant_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        grant_pred = 1'b0; model_busy = 1'b0; have_cur = 1'b0; resp_m = 1'b0;
        resp_pend = 1'b0; aw_done_m = 1'b0; last_unc_m = 1'b0; beats_seen = 0;
        awv_prev = 1'b0; aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
        unc_done_prev = 1'b0; wb_done_prev = 1'b0;
        unc_req = 1'b0; wb_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock cycle: observe and check outputs, drive inputs, predict, advance.
    task automatic step();
        logic gp, pick, done_any;
        int   bi;
        gp = grant_pred;
        grant_pred = 1'b0;
        if (gp) begin
            cur = pred_txn; have_cur = 1'b1; model_busy = 1'b1;
            beats_seen = 0; aw_done_m = 1'b0; resp_m = 1'b0;
        end
        check("aw_start", awvalid && !awv_prev, gp);
        if (resp_pend) begin resp_m = 1'b1; resp_pend = 1'b0; end
        done_any = unc_done | wb_done;
        check("err_o", err_o, done_any && (cur.bresp != 2'b00));
        if (done_any) begin
            check("done_expected", have_cur, 1'b1);
            check("done_owner", {unc_done, wb_done}, cur.is_unc ? 2'b10 : 2'b01);
            check("beats_at_done", beats_seen, cur.len + 1);
            grant_log.push_back(unc_done);
            if (unc_done) lat_unc = cyc - rise_unc;
            else lat_wb = cyc - rise_wb;
            if (err_o) n_err++;
            model_busy = 1'b0; have_cur = 1'b0; resp_m = 1'b0;
        end
        check("busy_o", busy_o, model_busy);
        check("bready", bready, resp_m);
        check("aw_w_overlap", awvalid & wvalid, 1'b0);
        if (aw_stall_prev) check("aw_hold", {awvalid, awaddr, awlen, awsize, awburst, awid}, aw_snap);
        if (w_stall_prev) check("w_hold", {wvalid, wdata, wstrb, wlast}, w_snap);

        // requesters: hold through done, drop the cycle after, maybe re-assert later
        if (unc_done_prev) unc_req = 1'b0;
        else if (!unc_req && unc_left > 0 && $urandom_range(99, 0) < req_pct) begin
            unc_req = 1'b1; unc_left--; rise_unc = cyc;
            if (!keep_inputs) begin
                unc_addr = $urandom & 32'hFFFF_FFFC; unc_data = $urandom;
                unc_wstrb = 4'($urandom_range(15, 1));
            end
        end
        if (wb_done_prev) wb_req = 1'b0;
        else if (!wb_req && wb_left > 0 && $urandom_range(99, 0) < req_pct) begin
            wb_req = 1'b1; wb_left--; rise_wb = cyc;
            if (!keep_inputs) begin wb_addr = $urandom; wb_data = rand256(); end
        end
        // the winner's inputs are latched, so disturb them
        if (gp) begin
            if (cur.is_unc) begin unc_addr = $urandom; unc_data = $urandom; unc_wstrb = 4'($urandom); end
            else begin wb_addr = $urandom; wb_data = rand256(); end
        end

        // slave side
        case (bp_mode)
            0: begin awready = 1'b1; wready = 1'b1; bvalid = 1'b1; end
            1: begin
                awready = 1'($urandom_range(1, 0)); wready = 1'($urandom_range(1, 0));
                bvalid = 1'($urandom_range(1, 0));
            end
            default: begin
                awready = awvalid && (aw_cnt >= 3);
                if (awvalid) aw_cnt++;
                wready = wvalid && wtog;
                if (wvalid) wtog = !wtog;
                bvalid = 1'b1;
            end
        endcase
        bresp = have_cur ? cur.bresp : 2'b00;
        bid = 4'($urandom);

        // handshakes taken at the coming edge
        if (awvalid && awready) begin
            check("aw_once", aw_done_m, 1'b0);
            check("awaddr", awaddr, cur.addr);
            check("awlen", awlen, cur.len);
            check("aw_fixed", {awid, awsize, awburst}, {4'd1, 3'd2, 2'b01});
            aw_done_m = 1'b1;
        end
        if (wvalid && wready) begin
            bi = beats_seen % 8;
            check("w_after_aw", aw_done_m, 1'b1);
            check("wdata", wdata, cur.data[32*bi +: 32]);
            check("wstrb", wstrb, cur.strb);
            check("wlast", wlast, beats_seen == int'(cur.len));
            if (beats_seen == int'(cur.len)) resp_pend = 1'b1;
            beats_seen++;
        end
        aw_stall_prev = awvalid && !awready;
        aw_snap = {14'd0, awvalid, awaddr, awlen, awsize, awburst, awid};
        if (aw_stall_prev) n_aw_stall++;
        w_stall_prev = wvalid && !wready;
        w_snap = {26'd0, wvalid, wdata, wstrb, wlast};
        if (w_stall_prev) n_w_stall++;
        awv_prev = awvalid;
        unc_done_prev = unc_done;
        wb_done_prev = wb_done;

        // grant prediction: idle, not a done cycle, any request pending
        if (!model_busy && !done_any && (unc_req || wb_req)) begin
            pick = unc_req && (!wb_req || !last_unc_m);
            last_unc_m = pick;
            pred_txn.is_unc = pick;
            pred_txn.addr   = pick ? unc_addr : {wb_addr[31:5], 5'd0};
            pred_txn.len    = pick ? 8'd0 : 8'd7;
            pred_txn.data   = pick ? {224'd0, unc_data} : wb_data;
            pred_txn.strb   = pick ? unc_wstrb : 4'hF;
            pred_txn.bresp  = (err_mode == 0) ? 2'b00 : (err_mode == 1) ? 2'b10 : 2'($urandom_range(3, 0));
            grant_pred = 1'b1;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input string tag, input int max_cyc);
        int k = 0;
        while ((unc_left > 0 || wb_left > 0 || unc_req || wb_req || model_busy || grant_pred) && k < max_cyc) begin
            step();
            k++;
        end
        check({tag, "_complete"}, k < max_cyc, 1'b1);
    endtask

    initial begin
        int k;
        bit exp_order [4];
        rst = 1'b1;
        unc_addr = 32'd0; unc_data = 32'd0; unc_wstrb = 4'd0; wb_addr = 32'd0; wb_data = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
        model_reset();
        bp_mode = 0; err_mode = 0; req_pct = 100; keep_inputs = 1'b1;
        unc_left = 0; wb_left = 0; aw_cnt = 0; wtog = 1'b1;
        n_err = 0; n_aw_stall = 0; n_w_stall = 0; lat_unc = 0; lat_wb = 0;

        // reset values
        @(posedge clk); #1;
        check("rst_awid", awid, 4'd1);
        check("rst_valids", {awvalid, wvalid, bready}, 3'b000);
        check("rst_flags", {unc_done, wb_done, err_o, busy_o}, 4'b0000);
        check("rst_aw", {awaddr, awlen, awsize, awburst}, 45'd0);
        check("rst_w", {wdata, wstrb, wlast}, 37'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single line drain
        wb_addr = 32'h1000_0013;
        for (int i = 0; i < 8; i++) wb_data[32*i +: 32] = 32'(i);
        wb_left = 1;
        run("line", 100);
        check("line_latency", lat_wb, 11);

        // uncached store
        unc_addr = 32'hBFAF_8000; unc_data = 32'hDEAD_BEEF; unc_wstrb = 4'b0011;
        unc_left = 1;
        run("unc", 100);
        check("unc_latency", lat_unc, 4);

        // contention from reset
        do_reset();
        keep_inputs = 1'b0;
        grant_log.delete();
        unc_left = 2; wb_left = 2;
        run("contention", 300);
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        check("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("grant_order", grant_log[i], exp_order[i]);

        // backpressure: awready low 3 cycles, wready toggling
        bp_mode = 2; aw_cnt = 0; wtog = 1'b1; n_aw_stall = 0; n_w_stall = 0;
        wb_left = 1;
        run("backpressure", 200);
        check("aw_stall_cycles", n_aw_stall, 3);
        check("w_stall_cycles", n_w_stall, 7);

        // error response on a line
        bp_mode = 0; err_mode = 1; n_err = 0;
        wb_left = 1;
        run("error", 100);
        check("err_with_done", n_err, 1);
        err_mode = 0;

        // reset in the middle of a burst
        wb_left = 1; k = 0;
        while (!(have_cur && beats_seen == 4) && k < 100) begin step(); k++; end
        check("rst_reach_beat4", beats_seen, 4);
        check("rst_beat4_wdata", wdata, cur.data[159:128]);
        rst = 1'b1;
        #1;
        check("rst_async_valids", {wvalid, awvalid, bready}, 3'b000);
        check("rst_async_busy", busy_o, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_no_done", {unc_done, wb_done}, 2'b00);
        end
        model_reset();
        rst = 1'b0;
        wb_left = 1;
        run("after_rst", 100);

        // randomized traffic with random backpressure and responses
        bp_mode = 1; err_mode = 2; req_pct = 40;
        unc_left = 12; wb_left = 12;
        run("random", 4000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
